regfile_wb_arbiter: RTL and testbench

Write-port controller for the 32×32 integer register file. After reset it zeroes registers x1..x31, which have no reset of their own. It then shares the file's single write port (A3/WD3/WE3) between the ALU writeback and the load/store unit (LSU) writeback using a valid/ready handshake with two-way round-robin arbitration. It sits between the execute/memory stages and the register file and is the only driver of the register file's write port.

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Controller phase: zeroing sweep, then normal arbitration.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_e;

  // Identity of a writeback requester.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } wb_req_e;

endpackage : wb_arb_pkg

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter (ALU vs LSU) with its last-grant memory.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_alu,
  input  logic i_req_lsu,
  output logic o_gnt_alu,
  output logic o_gnt_lsu
);
  import wb_arb_pkg::*;

  wb_req_e r_last_grant;

  // Grant: a lone requester wins; on a tie the one not served last time wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_gnt_alu = 1'b0;
    o_gnt_lsu = 1'b0;
    if (i_en) begin
      if (i_req_alu && i_req_lsu) begin
        o_gnt_alu = (r_last_grant == REQ_LSU);
        o_gnt_lsu = (r_last_grant == REQ_ALU);
      end else begin
        o_gnt_alu = i_req_alu;
        o_gnt_lsu = i_req_lsu;
      end
    end
  end

  // Remember the most recent winner; idle cycles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= REQ_LSU;  // ALU wins the first tie
    end else if (o_gnt_alu) begin
      r_last_grant <= REQ_ALU;
    end else if (o_gnt_lsu) begin
      r_last_grant <= REQ_LSU;
    end
  end

endmodule : rr_arbiter2

// File: rtl/regfile_wb_arbiter.sv
// Sole driver of the register file write port: zeroes x1..x(N-1) after
// reset, then arbitrates ALU and LSU writebacks onto one registered port.
module regfile_wb_arbiter #(
  parameter int XLEN           = wb_arb_pkg::XLEN,
  parameter int NUM_REGS       = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [$clog2(NUM_REGS)-1:0] alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  output logic                        alu_ready,
  input  logic                        lsu_valid,
  input  logic [$clog2(NUM_REGS)-1:0] lsu_rd,
  input  logic [XLEN-1:0]             lsu_data,
  output logic                        lsu_ready,
  output logic [$clog2(NUM_REGS)-1:0] rf_a3,
  output logic [XLEN-1:0]             rf_wd3,
  output logic                        rf_we3,
  output logic                        init_done
);
  import wb_arb_pkg::*;

  localparam int            AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

  wb_state_e     r_state;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_a3;
  logic [XLEN-1:0] r_wd3;
  logic          r_we3;
  logic          r_init_done;

  logic          w_gnt_alu;
  logic          w_gnt_lsu;
  logic          w_xfer;
  logic [AW-1:0] w_rd;
  logic [XLEN-1:0] w_data;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (r_state == RUN),
    .i_req_alu (alu_valid),
    .i_req_lsu (lsu_valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_lsu (w_gnt_lsu)
  );

  // Select the granted requester's destination and payload.
  always_comb begin
    w_xfer = w_gnt_alu | w_gnt_lsu;
    w_rd   = w_gnt_lsu ? lsu_rd   : alu_rd;
    w_data = w_gnt_lsu ? lsu_data : alu_data;
  end

  // Sweep/run FSM with registered write-port outputs.
  // NOTE: the register array itself has no reset, so x1..x(N-1) are cleared
  // by this sweep through the write port instead of by a wide reset net.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_cnt       <= AW'(1);
      r_a3        <= '0;
      r_wd3       <= '0;
      r_we3       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (r_state)
        CLEAR: begin
          if (!CLEAR_ON_RESET || (r_we3 && (r_a3 == LAST_REG))) begin
            // Last sweep write has been presented (or sweep disabled).
            r_state     <= RUN;
            r_we3       <= 1'b0;
            r_init_done <= 1'b1;
          end else begin
            r_we3 <= 1'b1;
            r_a3  <= r_cnt;
            r_wd3 <= '0;
            if (r_cnt != LAST_REG) begin
              r_cnt <= r_cnt + AW'(1);
            end
          end
        end
        RUN: begin
          // Writes to x0 are accepted but never reach the register file.
          if (w_xfer && (w_rd != '0)) begin
            r_we3 <= 1'b1;
            r_a3  <= w_rd;
            r_wd3 <= w_data;
          end else begin
            r_we3 <= 1'b0;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign alu_ready = w_gnt_alu;
  assign lsu_ready = w_gnt_lsu;
  assign rf_a3     = r_a3;
  assign rf_wd3    = r_wd3;
  assign rf_we3    = r_we3;
  assign init_done = r_init_done;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: sweep, single write, fairness,
// x0 suppression, back-pressure and mid-sweep reset.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            alu_ready;
  logic            lsu_valid = 1'b0;
  logic [4:0]      lsu_rd = '0;
  logic [XLEN-1:0] lsu_data = '0;
  logic            lsu_ready;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd3;
  logic            rf_we3;
  logic            init_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .XLEN           (XLEN),
    .NUM_REGS       (32),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .rf_we3    (rf_we3),
    .init_done (init_done)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release reset away from a clock edge; the next posedge is cycle 1.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs the sweep from cycle 1 to cycle 32, checking every cycle.
  task automatic check_sweep(input string tag);
    logic [39:0] got, exp;
    for (int n = 1; n <= 31; n++) begin
      step();
      got = {rf_we3, rf_a3, rf_wd3, init_done, alu_ready};
      exp = {1'b1, 5'(n), 32'h0, 1'b0, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d {we3,a3,wd3,init,alu_rdy}: got %h expected %h", tag, n, got, exp);
      end
    end
    step();
    n_cmp++;
    if ({init_done, rf_we3} !== 2'b10) begin
      n_err++;
      $display("FAIL %s cycle 32 {init_done,we3}: got %b expected 10", tag, {init_done, rf_we3});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_cmp++;
    if ({rf_we3, rf_a3, rf_wd3, init_done, alu_ready, lsu_ready} !== 41'h0) begin
      n_err++;
      $display("FAIL reset_values: got we3=%b a3=%0d wd3=%h init=%b rdy=%b%b expected all 0",
               rf_we3, rf_a3, rf_wd3, init_done, alu_ready, lsu_ready);
    end
    release_reset();
    check_sweep("sweep");
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL single_ready: got alu/lsu=%b%b expected 10", alu_ready, lsu_ready);
    end
    step();
    alu_valid = 1'b0;
    n_cmp++;
    if ({rf_we3, rf_a3, rf_wd3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL single_write: got we3=%b a3=%0d wd3=%h expected 1/5/deadbeef", rf_we3, rf_a3, rf_wd3);
    end
    step();
    n_cmp++;
    if ({rf_we3, rf_a3, rf_wd3} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL single_idle: got we3=%b a3=%0d wd3=%h expected 0/5/deadbeef", rf_we3, rf_a3, rf_wd3);
    end
  endtask

  task automatic test_x0();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if ({alu_ready, lsu_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL x0_ready: got alu/lsu=%b%b expected 01", alu_ready, lsu_ready);
    end
    step();
    lsu_valid = 1'b0;
    n_cmp++;
    if ({rf_we3, rf_a3, rf_wd3} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL x0_suppress: got we3=%b a3=%0d wd3=%h expected 0/5/deadbeef", rf_we3, rf_a3, rf_wd3);
    end
  endtask

  task automatic test_contention();
    // Last grant was LSU (x0 write), so the ALU wins the first tie.
    logic [1:0]  exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [37:0] exp_wr;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({alu_ready, lsu_ready} !== exp_rdy[i]) begin
        n_err++;
        $display("FAIL contention_grant[%0d]: got alu/lsu=%b%b expected %b", i, alu_ready, lsu_ready, exp_rdy[i]);
      end
      step();
      exp_wr = exp_rdy[i][1] ? {1'b1, 5'd1, 32'h11} : {1'b1, 5'd2, 32'h22};
      n_cmp++;
      if ({rf_we3, rf_a3, rf_wd3} !== exp_wr) begin
        n_err++;
        $display("FAIL contention_write[%0d]: got %h expected %h", i, {rf_we3, rf_a3, rf_wd3}, exp_wr);
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    n_cmp++;
    if (rf_we3 !== 1'b0) begin
      n_err++;
      $display("FAIL contention_idle: got we3=%b expected 0", rf_we3);
    end
  endtask

  task automatic test_back_to_back_hold();
    // Last grant was LSU, so the ALU wins this tie and the LSU must wait.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    #1;
    n_cmp++;
    if ({alu_ready, lsu_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL hold_stall: got alu/lsu=%b%b expected 10", alu_ready, lsu_ready);
    end
    step();
    alu_valid = 1'b0;
    n_cmp++;
    if ({rf_we3, rf_a3, rf_wd3} !== {1'b1, 5'd7, 32'h77}) begin
      n_err++;
      $display("FAIL hold_alu_write: got we3=%b a3=%0d wd3=%h expected 1/7/77", rf_we3, rf_a3, rf_wd3);
    end
    #1;
    n_cmp++;
    if ({alu_ready, lsu_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL hold_lsu_grant: got alu/lsu=%b%b expected 01", alu_ready, lsu_ready);
    end
    step();
    lsu_valid = 1'b0;
    n_cmp++;
    if ({rf_we3, rf_a3, rf_wd3} !== {1'b1, 5'd9, 32'h99}) begin
      n_err++;
      $display("FAIL hold_lsu_write: got we3=%b a3=%0d wd3=%h expected 1/9/99", rf_we3, rf_a3, rf_wd3);
    end
    step();
    n_cmp++;
    if (rf_we3 !== 1'b0) begin
      n_err++;
      $display("FAIL hold_idle: got we3=%b expected 0", rf_we3);
    end
  endtask

  task automatic test_mid_sweep_reset();
    rst_n = 1'b0;
    #7;
    release_reset();
    // A pending ALU request must stay unacknowledged during the sweep.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hCAFE0003;
    for (int n = 1; n <= 10; n++) step();
    n_cmp++;
    if ({rf_we3, rf_a3} !== {1'b1, 5'd10}) begin
      n_err++;
      $display("FAIL midreset_pre: got we3=%b a3=%0d expected 1/10", rf_we3, rf_a3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rf_we3, rf_a3, rf_wd3, init_done, alu_ready, lsu_ready} !== 41'h0) begin
      n_err++;
      $display("FAIL midreset_async: got we3=%b a3=%0d wd3=%h init=%b rdy=%b%b expected all 0",
               rf_we3, rf_a3, rf_wd3, init_done, alu_ready, lsu_ready);
    end
    release_reset();
    check_sweep("resweep");
    n_cmp++;
    if (alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL resweep_first_grant: got alu_ready=%b expected 1", alu_ready);
    end
    step();
    alu_valid = 1'b0;
    n_cmp++;
    if ({rf_we3, rf_a3, rf_wd3} !== {1'b1, 5'd3, 32'hCAFE0003}) begin
      n_err++;
      $display("FAIL resweep_first_write: got we3=%b a3=%0d wd3=%h expected 1/3/cafe0003", rf_we3, rf_a3, rf_wd3);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_x0();
    test_contention();
    test_back_to_back_hold();
    test_mid_sweep_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_wb_arbiter
